// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI bus master sequencer (sclk, active-low cs, mosi/miso on 1/2/4 lanes).
// One word per transaction, accepted on start && ready. All four CPOL/CPHA modes.
// Frame: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE, each phase H = clk_div + 1 cycles
// (XFER is 2*B half-periods of H cycles).
// Optional build macro SPI_MASTER_CTRL_LSB_FIRST_EN adds the lsb_first input.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ready,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [1:0]            lane_mode,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs,
  output logic [3:0]            mosi,
  input  logic [3:0]            miso
);

  localparam int EW = $clog2(2 * DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [EW-1:0]         ecnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  cpol_r;
  logic                  cpha_r;
  logic [1:0]            mode_r;
  logic [DIV_WIDTH-1:0]  div_r;
  logic                  lsb_r;
  logic                  lsb_in;
  logic                  half_done;
  logic                  sample_edge;
  logic [EW-1:0]         last_edge;

`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Number of active lanes for a lane_mode encoding; reserved falls back to single.
  function automatic logic [2:0] lanes_of(input logic [1:0] m);
    case (m)
      2'd2:    return 3'd4;
      2'd1:    return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Index of the final sclk edge of a frame: 2*B - 1.
  function automatic logic [EW-1:0] last_edge_of(input logic [1:0] m);
    case (m)
      2'd2:    return EW'(DATA_WIDTH / 2 - 1);
      2'd1:    return EW'(DATA_WIDTH - 1);
      default: return EW'(2 * DATA_WIDTH - 1);
    endcase
  endfunction

  // Next beat to put on mosi; unused lanes stay 0.
  function automatic logic [3:0] beat_of(input logic [DATA_WIDTH-1:0] w,
                                         input logic [1:0] m, input logic lsb);
    logic [3:0] b;
    b = '0;
    if (lsb) begin
      case (m)
        2'd2:    b = w[3:0];
        2'd1:    b[1:0] = w[1:0];
        default: b[0] = w[0];
      endcase
    end else begin
      case (m)
        2'd2:    b = w[DATA_WIDTH-1 -: 4];
        2'd1:    b[1:0] = w[DATA_WIDTH-1 -: 2];
        default: b[0] = w[DATA_WIDTH-1];
      endcase
    end
    return b;
  endfunction

  // Discard the beat just driven from the transmit shifter.
  function automatic logic [DATA_WIDTH-1:0] shift_of(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] m, input logic lsb);
    return lsb ? (w >> lanes_of(m)) : (w << lanes_of(m));
  endfunction

  // Merge one sampled miso beat into the receive shifter.
  function automatic logic [DATA_WIDTH-1:0] rx_next(input logic [DATA_WIDTH-1:0] r,
                                                    input logic [3:0] d,
                                                    input logic [1:0] m, input logic lsb);
    logic [DATA_WIDTH-1:0] t;
    if (lsb) begin
      t = r >> lanes_of(m);
      case (m)
        2'd2:    t[DATA_WIDTH-1 -: 4] = d;
        2'd1:    t[DATA_WIDTH-1 -: 2] = d[1:0];
        default: t[DATA_WIDTH-1] = d[0];
      endcase
    end else begin
      t = r << lanes_of(m);
      case (m)
        2'd2:    t[3:0] = d;
        2'd1:    t[1:0] = d[1:0];
        default: t[0] = d[0];
      endcase
    end
    return t;
  endfunction

  assign half_done   = (cnt == div_r);
  assign last_edge   = last_edge_of(mode_r);
  // Leading edges are the even-indexed ones; cpha selects which edge kind samples.
  assign sample_edge = (~ecnt[0]) ^ cpha_r;

  // Frame sequencer: all pin outputs and status are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ecnt     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      mode_r   <= '0;
      div_r    <= '0;
      lsb_r    <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      cs       <= 1'b1;
      mosi     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE) cnt <= half_done ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt  <= '0;
          ecnt <= '0;
          if (start) begin
            cpol_r <= cpol;
            cpha_r <= cpha;
            mode_r <= lane_mode;
            div_r  <= clk_div;
            lsb_r  <= lsb_in;
            sclk   <= cpol;
            cs     <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            rx_sr  <= '0;
            // With cpha=0 the first beat must be set up before the first (sampling) edge.
            if (!cpha) begin
              mosi  <= beat_of(tx_data, lane_mode, lsb_in);
              tx_sr <= shift_of(tx_data, lane_mode, lsb_in);
            end else begin
              tx_sr <= tx_data;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (half_done) state <= XFER;
        end
        XFER: begin
          if (half_done) begin
            sclk <= ~sclk;
            ecnt <= ecnt + 1'b1;
            if (sample_edge) begin
              rx_sr <= rx_next(rx_sr, miso, mode_r, lsb_r);
            end else if (ecnt != last_edge) begin
              mosi  <= beat_of(tx_sr, mode_r, lsb_r);
              tx_sr <= shift_of(tx_sr, mode_r, lsb_r);
            end
            if (ecnt == last_edge) begin
              ecnt  <= '0;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (half_done) begin
            cs       <= 1'b1;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            mosi     <= '0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (half_done) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: scoreboard of expected frames pushed at accept,
// popped and compared when rx_valid pulses; per-beat mosi checks during the frame.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int DW = 8;
  localparam int DV = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic [1:0]    lane_mode = '0;
  logic [DV-1:0] clk_div = '0;
  logic [DW-1:0] tx_data = '0;
  logic          ready, rx_valid, busy, sclk, cs;
  logic [DW-1:0] rx_data;
  logic [3:0]    mosi, miso;

  // Slave model: either echo mosi xor a lane pattern, or drive the pattern as a constant.
  logic          tie = 1'b0;
  logic [3:0]    pat = '0;
  assign miso = tie ? pat : (mosi ^ pat);

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(DV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .cpol      (cpol),
    .cpha      (cpha),
    .lane_mode (lane_mode),
    .clk_div   (clk_div),
    .tx_data   (tx_data),
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
    .lsb_first (1'b0),
`endif
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
    int unsigned   lanes;
    int unsigned   h;
    int unsigned   b;
    logic          cpol;
    logic          cpha;
  } rec_t;

  rec_t sbq[$];
  rec_t cur;
  rec_t got_rec;

  function automatic int unsigned lanes_of(input logic [1:0] m);
    return (m == 2'd2) ? 4 : (m == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic [3:0] lmask(input int unsigned l);
    return 4'((1 << l) - 1);
  endfunction

  // Bit i of the word travels on lane i % L in both directions.
  function automatic logic [DW-1:0] model_rx(input logic [DW-1:0] t, input int unsigned l,
                                             input logic ti, input logic [3:0] p);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = ti ? p[i % l] : (t[i] ^ p[i % l]);
    return r;
  endfunction

  function automatic logic [3:0] exp_beat(input rec_t e, input int unsigned k);
    if (k >= e.b) return 4'hF;
    return 4'(e.tx >> ((e.b - 1 - k) * e.lanes)) & lmask(e.lanes);
  endfunction

  // Monitor state
  bit          in_frame = 0;
  bit          unused_bad = 0;
  logic        sclk_prev = 1'b0;
  int unsigned lat = 0, cs_low = 0, edges = 0, beat_idx = 0;
  int unsigned cyc = 0, acc_cnt = 0, acc_last = 0, acc_gap = 0, rx_count = 0;

  // Monitor samples on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 0;
      sbq.delete();
      sclk_prev = sclk;
    end else begin
      if (in_frame) begin
        lat++;
        if (!cs) cs_low++;
        if (sclk !== sclk_prev) begin
          edges++;
          if ((edges % 2 == 1) != cur.cpha) begin
            check_val("mosi_beat", mosi & lmask(cur.lanes), exp_beat(cur, beat_idx));
            beat_idx++;
          end
        end
        if ((mosi & ~lmask(cur.lanes)) != 4'h0) unused_bad = 1;
      end
      if (rx_valid) begin
        rx_count++;
        check_val("rx_valid_expected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          got_rec = sbq.pop_front();
          check_val("rx_data", rx_data, got_rec.rx);
          check_val("latency", lat, 1 + (2 * got_rec.b + 2) * got_rec.h);
          check_val("cs_low_cycles", cs_low, (2 * got_rec.b + 2) * got_rec.h);
          check_val("sclk_edges", edges, 2 * got_rec.b);
          check_val("unused_mosi_zero", unused_bad, 0);
          check_val("idle_lines", {sclk, cs, mosi}, {got_rec.cpol, 1'b1, 4'h0});
        end
        in_frame = 0;
      end
      sclk_prev = sclk;
      if (start && ready) begin
        cur.tx    = tx_data;
        cur.lanes = lanes_of(lane_mode);
        cur.h     = clk_div + 1;
        cur.b     = DW / cur.lanes;
        cur.cpol  = cpol;
        cur.cpha  = cpha;
        cur.rx    = model_rx(tx_data, cur.lanes, tie, pat);
        sbq.push_back(cur);
        in_frame   = 1;
        lat        = 0;
        cs_low     = 0;
        edges      = 0;
        beat_idx   = 0;
        unused_bad = 0;
        sclk_prev  = cpol;
        acc_cnt++;
        acc_gap  = cyc - acc_last;
        acc_last = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic p, input logic h, input logic [1:0] m, input int unsigned d,
                         input logic [DW-1:0] t, input logic ti, input logic [3:0] pt);
    cpol = p; cpha = h; lane_mode = m; clk_div = DV'(d); tx_data = t; tie = ti; pat = pt;
  endtask

  task automatic wait_acc(input int unsigned target);
    int unsigned k;
    k = 0;
    while (acc_cnt < target && k < 1000) begin step(); k++; end
    if (acc_cnt < target) check_val("timeout_accept", acc_cnt, target);
  endtask

  task automatic wait_rx(input int unsigned target);
    int unsigned k;
    k = 0;
    while (rx_count < target && k < 2000) begin step(); k++; end
    if (rx_count < target) check_val("timeout_rx", rx_count, target);
  endtask

  // One frame; inputs are scrambled after accept to show they are not re-read.
  task automatic run_xfer(input logic p, input logic h, input logic [1:0] m, input int unsigned d,
                          input logic [DW-1:0] t, input logic ti, input logic [3:0] pt);
    int unsigned r0, a0;
    r0 = rx_count; a0 = acc_cnt;
    step();
    set_cfg(p, h, m, d, t, ti, pt);
    start = 1'b1;
    wait_acc(a0 + 1);
    start = 1'b0;
    check_val("ready_busy_after_accept", {ready, busy}, 2'b01);
    cpol = ~p; cpha = ~h; lane_mode = m + 2'd1; clk_div = DV'(d + 3); tx_data = ~t;
    wait_rx(r0 + 1);
  endtask

  initial begin
    int unsigned r0, a0, k;
    #12;
    check_val("rst_sclk", sclk, 0);
    check_val("rst_cs", cs, 1);
    check_val("rst_mosi", mosi, 0);
    check_val("rst_ready", ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_rx_data", rx_data, 0);
    check_val("rst_rx_valid", rx_valid, 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    run_xfer(1'b0, 1'b0, 2'd0, 1, 8'hA5, 1'b0, 4'h0);  // mode 0 single, loopback
    run_xfer(1'b1, 1'b1, 2'd0, 0, 8'h3C, 1'b1, 4'hF);  // mode 3 single, miso tied 1
    run_xfer(1'b0, 1'b0, 2'd2, 0, 8'h96, 1'b0, 4'h5);  // quad, miso C then 3
    run_xfer(1'b0, 1'b1, 2'd1, 2, 8'hE4, 1'b0, 4'h0);  // dual mode 1
    run_xfer(1'b1, 1'b0, 2'd3, 0, 8'h5A, 1'b0, 4'h1);  // mode 2, reserved lane mode
    run_xfer(1'b1, 1'b0, 2'd2, 3, 8'h1E, 1'b0, 4'hA);  // mode 2 quad, slower clock

    // Back-to-back with start held high
    r0 = rx_count; a0 = acc_cnt;
    step();
    set_cfg(1'b0, 1'b0, 2'd0, 0, 8'h11, 1'b0, 4'h0);
    start = 1'b1;
    wait_acc(a0 + 1);
    tx_data = 8'h22; lane_mode = 2'd2;
    wait_acc(a0 + 2);
    start = 1'b0;
    check_val("b2b_accept_spacing", acc_gap, (2 * 8 + 3) * 1 + 1);
    wait_rx(r0 + 2);

    // start while busy must not create an extra frame
    r0 = rx_count; a0 = acc_cnt;
    step();
    set_cfg(1'b0, 1'b0, 2'd0, 1, 8'h81, 1'b0, 4'h0);
    start = 1'b1;
    wait_acc(a0 + 1);
    start = 1'b0;
    repeat (6) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rx(r0 + 1);
    repeat (40) step();
    check_val("busy_start_accepts", acc_cnt, a0 + 1);
    check_val("busy_start_frames", rx_count, r0 + 1);

    // Reset in the middle of XFER after three sclk edges
    r0 = rx_count; a0 = acc_cnt;
    step();
    set_cfg(1'b0, 1'b0, 2'd0, 1, 8'hFF, 1'b0, 4'h0);
    start = 1'b1;
    wait_acc(a0 + 1);
    start = 1'b0;
    k = 0;
    while (edges < 3 && k < 500) begin step(); k++; end
    check_val("edges_before_reset", edges, 3);
    check_val("sclk_high_before_reset", sclk, 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_cs", cs, 1);
    check_val("midrst_sclk", sclk, 0);
    check_val("midrst_mosi", mosi, 0);
    check_val("midrst_ready", ready, 1);
    check_val("midrst_rx_valid", rx_valid, 0);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    check_val("no_rx_after_reset", rx_count, r0);

    run_xfer(1'b0, 1'b0, 2'd0, 0, 8'h3C, 1'b0, 4'h0);  // fresh frame after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Controller that sequences the SPI pin bundle (sclk, cs, mosi0-3, miso0-3) as bus master.
- Accepts one word per transaction over a valid/ready handshake.
- Generates sclk from the system clock with a programmable divider and frames the transfer with active-low cs.
- Shifts data out and in on 1, 2 or 4 lanes in all four CPOL/CPHA modes.
- Sits between the transaction source and the spi_if pins in hdl_top.

Parameters:
- DATA_WIDTH, 8: bits per transaction. Must be a multiple of 4 and at least 4.
- DIV_WIDTH, 8: width of the clk_div input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  transaction request; a transfer is accepted when start && ready.
- ready  output  1  high only in IDLE.
- cpol  input  1  sclk idle level. Sampled at accept.
- cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge. Sampled at accept.
- lane_mode  input  2  0 = single, 1 = dual, 2 = quad, 3 = reserved (treated as single). Sampled at accept.
- clk_div  input  DIV_WIDTH  half-period length minus 1. Sampled at accept.
- tx_data  input  DATA_WIDTH  word to transmit. Sampled at accept.
- rx_data  output  DATA_WIDTH  received word. Held until the next rx_valid.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  equal to !ready.
- sclk  output  1  SPI clock.
- cs  output  1  active-low chip select.
- mosi  output  4  mosi[0..3] map to mosi0..mosi3.
- miso  input  4  miso[0..3] map to miso0..miso3.

Behaviour:
- Reset values: sclk=0, cs=1, mosi=0, ready=1, busy=0, rx_data=0, rx_valid=0. All configuration registers reset to 0.
- Half period: H = clk_div + 1 clk cycles. A half-period counter runs in every state except IDLE.
- Lanes and beats: L = 1, 2 or 4 lanes; B = DATA_WIDTH / L beats per transaction.
- Data order: MSB first. In each beat the highest-numbered active lane carries the most significant bit of the group.
  - Example, quad mode, 8 bits: beat0 drives mosi3..0 = tx[7:4].
  - Unused mosi lanes are driven 0. Unused miso lanes are ignored.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE:
  - sclk = cpol of the last transfer (0 after reset); cs = 1.
  - On accept: latch the configuration and the shift register, then go to SETUP. cs falls on the clock edge after accept.
- SETUP (H cycles):
  - cs = 0, sclk at idle level.
  - If cpha=0, beat0 is driven at entry.
- XFER (2*B*H cycles): sclk toggles every H cycles, giving 2*B edges.
  - cpha=0: sample miso on the leading (odd) edges; shift out the next beat on the trailing edges, except after the last beat.
  - cpha=1: drive a beat on the leading edges (beat0 on the first); sample on the trailing edges.
- HOLD (H cycles):
  - sclk is back at idle level, cs = 0, mosi holds its last value.
  - On exit: cs = 1; rx_data is loaded; rx_valid pulses for 1 cycle; mosi returns to 0.
- GAP (H cycles): cs stays high, giving the minimum deselect time. Then go to IDLE.
- Total latency from the accept cycle to the rx_valid cycle: 1 + (2B + 2)*H cycles.
- start while busy: ignored. No queuing.
- start in the same cycle that GAP exits: not accepted, because ready is still 0. It is accepted on the next cycle.
- Inputs changing mid-transfer (cpol, cpha, lane_mode, clk_div, tx_data): no effect until the next accept.
- Reset asserted mid-transfer: all outputs return to reset values asynchronously. The partial rx word is discarded and no rx_valid is produced.
- miso is sampled by clk at the cycle where sclk makes its sampling transition. No synchronizer is used; the pins are treated as synchronous to clk.

Optional Feature:
- Macro: SPI_MASTER_CTRL_LSB_FIRST_EN.
- When defined: adds input port lsb_first (1 bit), sampled at accept.
  - When lsb_first=1, both tx and rx are LSB first, and the lowest-numbered lane carries the least significant bit of each group.
  - Example, quad mode, 8 bits: beat0 drives mosi3..0 = tx[3:0].
- When not defined: the port is absent and the order is always MSB first.

Test Plan:
- Mode 0, single lane, clk_div=1, tx=0xA5, miso0 loops back mosi0 -> sclk period 4 clk; 8 rising edges; mosi0 sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; rx_valid at accept+37 cycles.
- Mode 3 (cpol=1, cpha=1), single lane, clk_div=0, tx=0x3C, miso0 tied 1 -> sclk idles high; cs low for 18 cycles; rx_data=0xFF.
- Quad lane, mode 0, clk_div=0, tx=0x96 -> two beats: mosi3..0 = 4'h9 then 4'h6; miso driven 4'hC then 4'h3 gives rx_data=0xC3; total latency 1+6=7 cycles.
- Dual lane, mode 1, tx=0xE4 -> beats on mosi1..0 are 3,2,1,0; exactly 8 sclk edges; mosi2 and mosi3 stay 0 throughout.
- Back-to-back: start held high -> second accept occurs 1 cycle after GAP ends; cs is high for at least H cycles between frames; start raised while busy produces no extra frame.
- Reset mid-XFER after 3 edges -> cs=1, sclk=0, mosi=0 immediately; no rx_valid; a fresh transfer after reset completes correctly.
